reg_bank_sb: RTL
================

// Module: reg_bank_sb
// PURPOSE
//  Parametrised register bank with integrated scoreboard, successor to the single-cycle register bank.
//  Multi-port, zero-register and write-bypass aware; tracks in-flight destination registers between decode and write-back.
//  Raises a stall when a source or destination hazard exists, so the decode stage can hold the pipeline buffers.
//  Sits in decode: read data feeds the decode/execute buffer, write port driven from the memory/write-back path.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   register address width; bank holds 2**ADDR_W registers
//  NRD       2   number of combinational read ports
//  ZERO_REG  1   1: register 0 reads 0, never written, never pending
//  BYPASS    1   1: same-cycle write forwarded to matching read port and clears its busy
// PORTS
//  clk       in   1              rising-edge clock
//  rst_n     in   1              synchronous active-low reset
//  rd_addr   in   NRD*ADDR_W     read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_use    in   NRD            port k operand is actually needed by the decoding instruction
//  rd_data   out  NRD*DATA_W     read data, port k at [k*DATA_W +: DATA_W]
//  rd_busy   out  NRD            port k address has an outstanding producer
//  iss_en    in   1              decoding instruction requests issue with a destination
//  iss_addr  in   ADDR_W         destination register of issuing instruction
//  iss_ok    out  1              issue accepted this cycle (iss_en & ~stall)
//  stall     out  1              hold fetch/decode and the decode buffer this cycle
//  wr_en     in   1              write-back strobe
//  wr_addr   in   ADDR_W         write-back address
//  wr_data   in   DATA_W         write-back data
//  pend_cnt  out  ADDR_W+1       number of registers currently pending
// BEHAVIOUR
//  - One clock (clk), synchronous active-low reset (rst_n). Reset: all registers = 0, all pending bits = 0, pend_cnt = 0.
//    With inputs idle, outputs after reset: rd_data = 0, rd_busy = 0, stall = 0, iss_ok = 0.
//  - Write: on the clk edge with wr_en=1, reg[wr_addr] <= wr_data. Ignored for addr 0 when ZERO_REG=1.
//  - Read is combinational: rd_data_k = reg[rd_addr_k]. Forced to 0 for addr 0 when ZERO_REG=1.
//  - With BYPASS=1 and wr_en & wr_addr==rd_addr_k (non-zero): rd_data_k = wr_data and rd_busy_k = 0, same cycle.
//  - Write-clear condition: clr(a) = wr_en & wr_addr==a.
//  - Effective pending: pend_eff(a) = pending(a) & ~(BYPASS & clr(a)).
//  - rd_busy_k = pend_eff(rd_addr_k). Always 0 for addr 0 when ZERO_REG=1.
//  - stall = |(rd_use & rd_busy) | (iss_en & pend_eff(iss_addr)), where the iss_en term is the WAW hazard.
//  - iss_ok = iss_en & ~stall.
//  - Scoreboard update at the clk edge:
//      - wr_en clears pending(wr_addr).
//      - iss_ok sets pending(iss_addr); set wins on the same address in the same cycle.
//      - Issue to addr 0 with ZERO_REG=1: accepted, pending not set.
//  - pend_cnt holds the population count of pending, updated in the same edge.
//    - +1 on set only, -1 on clear only, unchanged on simultaneous set+clear of the same address.
//    - Never wraps, because the count cannot exceed 2**ADDR_W.
//  - wr_en to a non-pending address is legal: the register is written, pending is unchanged.
//  - Reset mid-operation: rst_n=0 at an edge discards all pending and data. Write and issue in that cycle have no effect.
//  - Latency: read 0 cycles; write visible to a non-bypassed read 1 cycle after the edge; scoreboard changes visible after the edge.
// TESTING
//  T1 reset: write r5=0xDEAD; then rst_n=0 for 1 edge -> rd r5 = 0, pend_cnt = 0, stall = 0.
//  T2 RAW stall: issue r3 (iss_ok=1); next cycle rd_addr0=3, rd_use0=1 -> rd_busy0=1, stall=1.
//     - wr r3=0x1234 that cycle -> busy0=0, rd_data0=0x1234, stall=0.
//  T3 WAW: pending r7; iss_en r7 with no write -> stall=1, iss_ok=0.
//     - Same request with wr r7 in the same cycle -> iss_ok=1; r7 still pending after the edge; pend_cnt unchanged.
//  T4 zero reg: wr r0=0xFFFF; issue r0 -> rd r0 = 0, rd_busy=0, pend_cnt=0.
//  T5 unused operand: r9 pending, rd_addr1=9, rd_use1=0 -> rd_busy1=1, stall=0.
//  T6 count: issue r1..r31 on successive cycles -> pend_cnt=31; write back all -> pend_cnt=0.
//     - Also check NRD=3, DATA_W=64 build passes T2.

Source files
------------

// File: rtl/reg_bank_sb_if.sv
// reg_bank_sb_if: read, issue and write-back bus of the scoreboarded register bank.
interface reg_bank_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD = 2
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD-1:0] rd_use;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0] rd_busy;
    logic iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic iss_ok;
    logic stall;
    logic wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0] pend_cnt;
    modport master (
        output rd_addr, rd_use, iss_en, iss_addr, wr_en, wr_addr, wr_data,
        input rd_data, rd_busy, iss_ok, stall, pend_cnt
    );
    modport slave (
        input rd_addr, rd_use, iss_en, iss_addr, wr_en, wr_addr, wr_data,
        output rd_data, rd_busy, iss_ok, stall, pend_cnt
    );
endinterface

// File: rtl/reg_bank_sb.sv
// reg_bank_sb: multi-port register bank with write bypass and a pending-destination scoreboard.
module reg_bank_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS = 1
) (
    input logic clk,
    input logic rst_n,
    reg_bank_sb_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam int CW = ADDR_W + 1;
    logic [DATA_W-1:0] regFile [NREG];
    logic [DATA_W-1:0] rdData [NRD];
    logic [NREG-1:0] pending, clrVec, setVec, pendEff;
    logic [NRD-1:0] rdBusy;
    logic [ADDR_W:0] pendCnt;
    logic issZero, wrZero, stallInt, issOk, pendInc, pendDec;
    assign issZero = (ZERO_REG != 0) && bus.iss_addr == '0;
    assign wrZero = (ZERO_REG != 0) && bus.wr_addr == '0;
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            clrVec[i] = bus.wr_en && bus.wr_addr == ADDR_W'(i);
            setVec[i] = issOk && !issZero && bus.iss_addr == ADDR_W'(i);
        end
    end
    // A write-back in flight this cycle already satisfies any waiter on that register.
    assign pendEff = pending & ~((BYPASS != 0) ? clrVec : '0);
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic z, hit;
        assign a = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign z = (ZERO_REG != 0) && a == '0;
        assign hit = (BYPASS != 0) && bus.wr_en && bus.wr_addr == a;
        assign rdData[k] = z ? '0 : hit ? bus.wr_data : regFile[a];
        assign rdBusy[k] = !z && pendEff[a];
    end
    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NRD; i++) bus.rd_data[i*DATA_W +: DATA_W] = rdData[i];
    end
    assign stallInt = |(bus.rd_use & rdBusy) || (bus.iss_en && pendEff[bus.iss_addr]);
    assign issOk = bus.iss_en && !stallInt;
    // A set on a register cleared in the same cycle leaves the population unchanged.
    assign pendInc = |(setVec & ~pending);
    assign pendDec = |(clrVec & pending & ~setVec);
    assign bus.rd_busy = rdBusy;
    assign bus.stall = stallInt;
    assign bus.iss_ok = issOk;
    assign bus.pend_cnt = pendCnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            pendCnt <= '0;
            for (int i = 0; i < NREG; i++) regFile[i] <= '0;
        end else begin
            pending <= (pending & ~clrVec) | setVec;
            pendCnt <= pendCnt + CW'(pendInc) - CW'(pendDec);
            if (bus.wr_en && !wrZero) regFile[bus.wr_addr] <= bus.wr_data;
        end
    end
endmodule
